// File: rtl/calc_rotation_pipeline_pkg.sv
// Shared fixed-point constants and helpers for the Jacobi rotation datapath.
// Angles use the data format: JACOBI_PI is pi scaled by 2^JACOBI_FRAC_BITS.
package calc_rotation_pipeline_pkg;

    localparam int JACOBI_OUTPUT_WORD_WIDTH = 16;
    localparam int JACOBI_FRAC_BITS         = 13;
    localparam int CORDIC_N_STAGES          = 16;

    // Extra LSBs carried inside the CORDIC so that shift truncation and atan
    // table quantisation stay well below one output LSB.
    localparam int CORDIC_FRAC_EXT          = 4;
    localparam int CORDIC_ATAN_FRAC         = JACOBI_FRAC_BITS + CORDIC_FRAC_EXT;

    localparam logic signed [15:0] JACOBI_PI          = 16'sd25736;
    localparam logic signed [15:0] JACOBI_CORDIC_KINV = 16'sd4975;

    typedef logic signed [31:0] atan_t;
    typedef logic signed [63:0] fxp_t;

    typedef enum logic [1:0] {
        FOLD_NONE = 2'd0,
        FOLD_POS  = 2'd1,
        FOLD_NEG  = 2'd2
    } fold_e;

    localparam int CORDIC_ATAN_LEN = 20;

    // atan(2^-i) scaled by 2^CORDIC_ATAN_FRAC, rounded to nearest.
    localparam atan_t CORDIC_ATAN [CORDIC_ATAN_LEN] = '{
        32'sd102944, 32'sd60771, 32'sd32110, 32'sd16299,
        32'sd8181,   32'sd4095,  32'sd2048,  32'sd1024,
        32'sd512,    32'sd256,   32'sd128,   32'sd64,
        32'sd32,     32'sd16,    32'sd8,     32'sd4,
        32'sd2,      32'sd1,     32'sd0,     32'sd0
    };

    function automatic atan_t cordic_atan(input int i);
        if (i < 0 || i >= CORDIC_ATAN_LEN) begin
            return '0;
        end
        return CORDIC_ATAN[i];
    endfunction

    // Round half up while dropping frac LSBs.
    function automatic fxp_t fxp_round(input fxp_t v, input int unsigned frac);
        fxp_t half;
        if (frac == 0) begin
            return v;
        end
        half = fxp_t'(1) <<< (frac - 1);
        return (v + half) >>> frac;
    endfunction

    // Clip to the signed range of a w-bit word.
    function automatic fxp_t fxp_saturate(input fxp_t v, input int unsigned w);
        fxp_t hi;
        fxp_t lo;
        hi = (fxp_t'(1) <<< (w - 1)) - fxp_t'(1);
        lo = -(fxp_t'(1) <<< (w - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/calc_rotation_pipeline_cordic.sv
// Pipelined CORDIC, one register per micro-rotation, shared between the angle
// calculator (vectoring) and the rotation pipeline (rotation).
module calc_rotation_pipeline_cordic
    import calc_rotation_pipeline_pkg::*;
#(
    parameter string MODE     = "rotation",
    parameter int    IW       = 22,
    parameter int    N_STAGES = CORDIC_N_STAGES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [IW-1:0] x_i,
    input  logic signed [IW-1:0] y_i,
    input  logic signed [IW-1:0] z_i,
    input  logic                 vld_i,
    output logic signed [IW-1:0] x_o,
    output logic signed [IW-1:0] y_o,
    output logic signed [IW-1:0] z_o,
    output logic                 vld_o
);

    for (genvar i = 0; i < N_STAGES; i++) begin : g_stage
        localparam logic signed [IW-1:0] ATAN_I = IW'(cordic_atan(i));

        logic signed [IW-1:0] x_in;
        logic signed [IW-1:0] y_in;
        logic signed [IW-1:0] z_in;
        logic                 v_in;
        logic signed [IW-1:0] x_sh;
        logic signed [IW-1:0] y_sh;
        logic                 d_pos;
        logic signed [IW-1:0] x_q;
        logic signed [IW-1:0] y_q;
        logic signed [IW-1:0] z_q;
        logic                 v_q;

        if (i == 0) begin : g_first
            assign x_in = x_i;
            assign y_in = y_i;
            assign z_in = z_i;
            assign v_in = vld_i;
        end else begin : g_chain
            assign x_in = g_stage[i-1].x_q;
            assign y_in = g_stage[i-1].y_q;
            assign z_in = g_stage[i-1].z_q;
            assign v_in = g_stage[i-1].v_q;
        end

        // Rotation drives z to zero (z >= 0 rotates positive); vectoring drives y to zero.
        if (MODE == "vectoring") begin : g_vec
            assign d_pos = y_in[IW-1];
        end else begin : g_rot
            assign d_pos = ~z_in[IW-1];
        end

        assign x_sh = x_in >>> i;
        assign y_sh = y_in >>> i;

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
            end else begin
                v_q <= v_in;
            end
        end

        always_ff @(posedge clk) begin
            if (d_pos) begin
                x_q <= x_in - y_sh;
                y_q <= y_in + x_sh;
                z_q <= z_in - ATAN_I;
            end else begin
                x_q <= x_in + y_sh;
                y_q <= y_in - x_sh;
                z_q <= z_in + ATAN_I;
            end
        end
    end

    assign x_o   = g_stage[N_STAGES-1].x_q;
    assign y_o   = g_stage[N_STAGES-1].y_q;
    assign z_o   = g_stage[N_STAGES-1].z_q;
    assign vld_o = g_stage[N_STAGES-1].v_q;

endmodule

// File: rtl/calc_rotation_pipeline.sv
// Rotates (x, y) by a signed angle: quadrant fold, rotation-mode CORDIC,
// 1/K gain compensation, then round and saturate back to the data format.
module calc_rotation_pipeline
    import calc_rotation_pipeline_pkg::*;
#(
    parameter int W        = JACOBI_OUTPUT_WORD_WIDTH,
    parameter int N_STAGES = CORDIC_N_STAGES,
    parameter int GUARD    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [W-1:0] x_i,
    input  logic signed [W-1:0] y_i,
    input  logic signed [W-1:0] angle_i,
    input  logic                vld_i,
    output logic signed [W-1:0] x_o,
    output logic signed [W-1:0] y_o,
    output logic                vld_o
);

    localparam int FE  = CORDIC_FRAC_EXT;
    localparam int IW  = W + GUARD + FE;
    localparam int EXT = IW - W - 1 - FE;
    localparam int PW  = IW + W;
    localparam int unsigned RSH = JACOBI_FRAC_BITS + FE;

    localparam logic signed [W:0]   PI_W      = (W+1)'(JACOBI_PI);
    localparam logic signed [W:0]   HALF_PI_W = PI_W >>> 1;
    localparam logic signed [W-1:0] KINV_W    = W'(JACOBI_CORDIC_KINV);

    // Fold is computed at W+1 bits so negating the most-negative input cannot wrap.
    logic signed [W:0] angle_x;
    logic signed [W:0] angle_c;
    logic signed [W:0] x_ext;
    logic signed [W:0] y_ext;
    logic signed [W:0] x_fold;
    logic signed [W:0] y_fold;
    logic signed [W:0] z_fold;
    fold_e             fold;

    always_comb begin
        angle_x = {angle_i[W-1], angle_i};
        angle_c = angle_x;
        if (angle_x > PI_W) begin
            angle_c = PI_W;
        end else if (angle_x < -PI_W) begin
            angle_c = -PI_W;
        end

        fold = FOLD_NONE;
        if (angle_c > HALF_PI_W) begin
            fold = FOLD_POS;
        end else if (angle_c < -HALF_PI_W) begin
            fold = FOLD_NEG;
        end

        x_ext  = {x_i[W-1], x_i};
        y_ext  = {y_i[W-1], y_i};
        x_fold = x_ext;
        y_fold = y_ext;
        z_fold = angle_c;
        case (fold)
            FOLD_POS: begin
                z_fold = angle_c - PI_W;
                x_fold = -x_ext;
                y_fold = -y_ext;
            end
            FOLD_NEG: begin
                z_fold = angle_c + PI_W;
                x_fold = -x_ext;
                y_fold = -y_ext;
            end
            default: begin
            end
        endcase
    end

    logic signed [IW-1:0] x0;
    logic signed [IW-1:0] y0;
    logic signed [IW-1:0] z0;
    logic                 vld0;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld0 <= 1'b0;
        end else begin
            vld0 <= vld_i;
        end
    end

    always_ff @(posedge clk) begin
        x0 <= {{EXT{x_fold[W]}}, x_fold, {FE{1'b0}}};
        y0 <= {{EXT{y_fold[W]}}, y_fold, {FE{1'b0}}};
        z0 <= {{EXT{z_fold[W]}}, z_fold, {FE{1'b0}}};
    end

    logic signed [IW-1:0] cx;
    logic signed [IW-1:0] cy;
    logic signed [IW-1:0] cordic_z_unused;
    logic                 cvld;

    calc_rotation_pipeline_cordic #(
        .MODE     ("rotation"),
        .IW       (IW),
        .N_STAGES (N_STAGES)
    ) u_cordic (
        .clk   (clk),
        .rst   (rst),
        .x_i   (x0),
        .y_i   (y0),
        .z_i   (z0),
        .vld_i (vld0),
        .x_o   (cx),
        .y_o   (cy),
        .z_o   (cordic_z_unused),
        .vld_o (cvld)
    );

    // Full-width products: CORDIC_ATAN_FRAC + JACOBI_FRAC_BITS fractional bits.
    logic signed [PW-1:0] gx;
    logic signed [PW-1:0] gy;
    logic                 gvld;

    always_ff @(posedge clk) begin
        if (rst) begin
            gvld <= 1'b0;
        end else begin
            gvld <= cvld;
        end
    end

    always_ff @(posedge clk) begin
        gx <= PW'(cx) * PW'(KINV_W);
        gy <= PW'(cy) * PW'(KINV_W);
    end

    logic signed [W-1:0] x_sat;
    logic signed [W-1:0] y_sat;

    always_comb begin
        x_sat = W'(fxp_saturate(fxp_round(fxp_t'(gx), RSH), W));
        y_sat = W'(fxp_saturate(fxp_round(fxp_t'(gy), RSH), W));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_o   <= '0;
            y_o   <= '0;
            vld_o <= 1'b0;
        end else begin
            x_o   <= x_sat;
            y_o   <= y_sat;
            vld_o <= gvld;
        end
    end

endmodule

// File: tb/tb_calc_rotation_pipeline.sv
// Bench for calc_rotation_pipeline: directed rotations, a gapped random stream
// against a real-valued model, and a mid-flight reset.
`timescale 1ns/1ps
module tb_calc_rotation_pipeline;
    import calc_rotation_pipeline_pkg::*;

    localparam int W   = JACOBI_OUTPUT_WORD_WIDTH;
    localparam int LAT = CORDIC_N_STAGES + 3;

    typedef struct packed {
        logic signed [W-1:0] x;
        logic signed [W-1:0] y;
        logic [7:0]          tol_x;
        logic [7:0]          tol_y;
        int                  cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    logic                clk = 1'b0;
    logic                rst;
    logic signed [W-1:0] x_i;
    logic signed [W-1:0] y_i;
    logic signed [W-1:0] angle_i;
    logic                vld_i;
    logic signed [W-1:0] x_o;
    logic signed [W-1:0] y_o;
    logic                vld_o;

    int cycle  = 0;
    int n_vec  = 0;
    int n_fail = 0;

    calc_rotation_pipeline dut (
        .clk     (clk),
        .rst     (rst),
        .x_i     (x_i),
        .y_i     (y_i),
        .angle_i (angle_i),
        .vld_i   (vld_i),
        .x_o     (x_o),
        .y_o     (y_o),
        .vld_o   (vld_o)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check_val(input string name, input int act, input int req, input int tol);
        int diff;
        diff = act - req;
        n_vec++;
        if (diff > tol || diff < -tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d) at cycle %0d", name, act, req, tol, cycle);
        end
    endtask

    function automatic int rnd(input real r);
        return (r >= 0.0) ? $rtoi(r + 0.5) : $rtoi(r - 0.5);
    endfunction

    function automatic int sat(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Ideal rotation by the clamped angle, rounded and saturated
    task automatic model(input int x, input int y, input int a, output int ex, output int ey);
        int  ac;
        real th;
        ac = a;
        if (ac > 25736) ac = 25736;
        if (ac < -25736) ac = -25736;
        th = real'(ac) / 8192.0;
        ex = sat(rnd(real'(x) * $cos(th) - real'(y) * $sin(th)));
        ey = sat(rnd(real'(x) * $sin(th) + real'(y) * $cos(th)));
    endtask

    // Driver tasks
    task automatic drive(input int x, input int y, input int a);
        @(negedge clk);
        x_i     = W'(x);
        y_i     = W'(y);
        angle_i = W'(a);
        vld_i   = 1'b1;
    endtask

    task automatic send(input int x, input int y, input int a,
                        input int ex, input int ey, input int tx, input int ty);
        exp_t e;
        drive(x, y, a);
        e.x     = W'(ex);
        e.y     = W'(ey);
        e.tol_x = 8'(tx);
        e.tol_y = 8'(ty);
        e.cyc   = cycle;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            x_i     = W'($urandom_range(0, 65535));
            y_i     = W'($urandom_range(0, 65535));
            angle_i = W'($urandom_range(0, 65535));
            vld_i   = 1'b0;
        end
    endtask

    task automatic drain();
        idle(1);
        for (int k = 0; k < LAT + 20 && exp_q.size() != 0; k++) idle(1);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL drain: %0d outputs still pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (vld_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_output: vld_o=1 with x_o=%0d y_o=%0d, expected no output at cycle %0d",
                         x_o, y_o, cycle);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("x_o", int'(x_o), int'(mon_e.x), int'(mon_e.tol_x));
                check_val("y_o", int'(y_o), int'(mon_e.y), int'(mon_e.tol_y));
                check_val("latency", cycle - mon_e.cyc, LAT, 0);
            end
        end
    end

    initial begin
        int x, y, a, ex, ey;
        rst     = 1'b1;
        vld_i   = 1'b0;
        x_i     = '0;
        y_i     = '0;
        angle_i = '0;
        repeat (3) @(negedge clk);
        check_val("reset_vld_o", int'(vld_o), 0, 0);
        check_val("reset_x_o", int'(x_o), 0, 0);
        check_val("reset_y_o", int'(y_o), 0, 0);
        rst = 1'b0;

        // Directed vectors
        send(4096, 0, 12868, 0, 4096, 3, 3);
        send(4096, 0, 25736, -4096, 0, 3, 3);
        send(4096, 0, 30000, -4096, 0, 3, 3);
        send(2048, 2048, -19302, 0, -2896, 3, 3);
        send(32767, 32767, 6434, 0, 32767, 3, 0);
        send(-32768, 0, 25736, 32767, 0, 3, 3);
        send(0, 4096, -12868, 4096, 0, 3, 3);
        idle(4);

        // Gapped random stream
        for (int n = 0; n < 64; n++) begin
            idle($urandom_range(0, 2));
            x = int'($urandom_range(0, 16000)) - 8000;
            y = int'($urandom_range(0, 16000)) - 8000;
            a = int'($urandom_range(0, 65535)) - 32768;
            model(x, y, a, ex, ey);
            send(x, y, a, ex, ey, 3, 3);
        end
        drain();

        // Reset with five samples in flight: none may emerge
        for (int n = 0; n < 5; n++) drive(1000 * (n + 1), -500, 3000 * n);
        @(negedge clk);
        vld_i = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("midreset_vld_o", int'(vld_o), 0, 0);
        check_val("midreset_x_o", int'(x_o), 0, 0);
        check_val("midreset_y_o", int'(y_o), 0, 0);
        idle(LAT + 5);

        // Pipeline still works after reset
        send(4096, 0, 12868, 0, 4096, 3, 3);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/calc_rotation_pipeline.md
Name: calc_rotation_pipeline

Overview:
- Inverse companion of the vectoring angle calculator: rotates a 2-D vector (x_i, y_i) by a signed angle.
- Produces (x·cos θ − y·sin θ, x·sin θ + y·cos θ), fully pipelined, one sample per clock.
- Used in the Jacobi update datapath to apply the Givens rotation computed by the angle stage to matrix element pairs.
- Built around a rotation-mode CORDIC with quadrant folding at the input and gain compensation at the output.

Parameters:
- W, JACOBI_OUTPUT_WORD_WIDTH, data and angle word width (two's complement, same fixed-point format as the angle calculator output).
- N_STAGES, CORDIC_N_STAGES, number of CORDIC micro-rotation stages.
- GUARD, 2, extra MSBs carried inside the CORDIC to absorb gain growth (K ≈ 1.647) and the √2 diagonal magnitude.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active high
- x_i  in  W  signed vector x component
- y_i  in  W  signed vector y component
- angle_i  in  W  signed rotation angle, same format as JACOBI_PI
- vld_i  in  1  input sample valid
- x_o  out  W  signed rotated x
- y_o  out  W  signed rotated y
- vld_o  out  1  output valid

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. At reset, every valid register in the pipe, including vld_o, clears to 0, and x_o/y_o clear to 0. The datapath registers in the middle of the pipe need not be reset.
- Throughput: one sample per cycle, no backpressure, no stall. vld only qualifies data.
- Latency: exactly N_STAGES+3 cycles from vld_i to vld_o.
  - Stage 0: input fold register.
  - N_STAGES: CORDIC.
  - Stage N+1: gain multiply.
  - Stage N+2: round/saturate/output register.
- Stage 0, input fold (registered):
  - Clamp: angle_i > JACOBI_PI → JACOBI_PI; angle_i < −JACOBI_PI → −JACOBI_PI.
  - If clamped angle > JACOBI_PI/2: z0 = angle − JACOBI_PI, x0 = −x_i, y0 = −y_i.
  - If clamped angle < −JACOBI_PI/2: z0 = angle + JACOBI_PI, x0 = −x_i, y0 = −y_i.
  - Otherwise pass through unchanged. angle == ±JACOBI_PI/2 exactly is not folded.
  - Negation of the most-negative value is done at W+1 bits, so there is no wrap.
  - x0/y0 are sign-extended to W+GUARD.
- CORDIC, rotation mode:
  - Stage i: d = sign(z), with z ≥ 0 treated as +1.
  - x += −d·(y>>>i), y += d·(x>>>i), z −= d·atan(2^−i).
  - Uses arithmetic shifts. The atan table lives in the package.
  - Carries vld alongside the data.
- Gain stage: multiply x and y by JACOBI_CORDIC_KINV (≈0.607253 in the data format). Keep the full product width.
- Output stage:
  - Round with fxp_round back to the data format.
  - Saturate to [−2^(W−1), 2^(W−1)−1].
  - Register to x_o/y_o.
  - vld_o is the delayed vld.
- Invalid cycles: data still propagates, and outputs may change while vld_o = 0. Consumers sample only when vld_o = 1.
- Reset mid-operation: all in-flight valids are discarded. vld_o stays 0 until a vld_i sampled after rst deasserts emerges N_STAGES+3 cycles later.
- Accuracy: |error| ≤ 3 LSB per component for non-saturating results, with N_STAGES ≥ W−2.

Decomposition:
- Package common holds: JACOBI_OUTPUT_WORD_WIDTH, JACOBI_PI, CORDIC_N_STAGES, the CORDIC atan table, JACOBI_CORDIC_KINV, and fxp_round. Add fxp_saturate there as well.
- One sub-module: the shared cordic, instantiated with MODE("rotation"). It is parameterised for internal width W+GUARD and propagates vld.
- Fold, gain and saturate logic stay in calc_rotation_pipeline.

Test Plan (W=16, 13 fractional bits, JACOBI_PI=25736, tolerance ±3 LSB):
- Quarter turn: x=4096, y=0, angle=12868 (π/2) → x_o≈0, y_o≈4096, vld_o exactly N_STAGES+3 cycles after vld_i.
- Fold, positive: x=4096, y=0, angle=25736 (π) → x_o≈−4096, y_o≈0. Also angle=30000 (clamped to π) gives the same result.
- Fold, negative: x=2048, y=2048, angle=−19302 (−3π/4) → x_o≈0, y_o≈−2896.
- Saturation: x=y=32767, angle=6434 (π/4) → x_o≈0, y_o=32767 (saturated, no wrap). Likewise x=−32768, y=0, angle=25736 → x_o=32767.
- Streaming: 64 back-to-back random valid samples with vld_i gaps → outputs match the reference model in order, one per valid, none dropped or duplicated.
- Reset mid-flight: assert rst for 1 cycle while 5 samples are in flight → vld_o=0, x_o=y_o=0 the next cycle; no stale valid emerges afterwards.
